quant_pipe: RTL

- Streaming, parametrised requantization unit: int32 conv/FC accumulator in, clamped OUT_WIDTH activation out.
- Operation order: add bias, then per-channel TFLite-style fixed-point multiply (SRDHM + rounding divide by power of two), then output offset, then clamp.
- Multiplier, shift and bias are held per channel in CHANNELS-deep tables; offset and clamp bounds are global.
- Sits between the MAC accumulator and the output store inside the CFU.
- Five-stage pipeline, one result per cycle, valid/ready on both sides.

---
 rtl/quant_pkg.sv | 37 +++
 rtl/rdbp_stage.sv | 54 +++++
 rtl/quant_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/quant_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quant_pkg : shared encodings, constants and payload type for quant_pipe|
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package quant_pkg;

  typedef enum logic [2:0] {
    SEL_BIAS       = 3'd0,
    SEL_MULT       = 3'd1,
    SEL_SHIFT      = 3'd2,
    SEL_ACT_MIN    = 3'd3,
    SEL_ACT_MAX    = 3'd4,
    SEL_OUT_OFFSET = 3'd5
  } cfg_sel_e;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;

  localparam int SHIFT_MIN = -31;
  localparam int SHIFT_MAX = 30;

  // SRDHM: (ab + nudge) / 2^31 with truncation toward zero
  localparam logic signed [63:0] SRDHM_NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] SRDHM_NUDGE_NEG = -64'sd1073741823;
  localparam logic signed [63:0] SRDHM_TRUNC_ADJ = 64'sd2147483647;

  localparam int STAGE_CH_W = 16;

  typedef struct packed {
    logic signed [31:0]      value;
    logic [STAGE_CH_W-1:0]   chan;
    logic                    ovf;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/rdbp_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rdbp_stage : registered rounding divide by 2^right, half away from 0  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module rdbp_stage #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = 5,
  parameter int TAG_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_value,
  input  logic [SHIFT_W-1:0]      in_right,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_value,
  output logic [TAG_W-1:0]        out_tag
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]        w_mask;
  logic [WIDTH-1:0]        w_rem;
  logic [WIDTH-1:0]        w_thr;
  logic signed [WIDTH-1:0] w_quot;
  logic signed [WIDTH-1:0] w_result;
  logic                    w_round_up;

  // Negative values need a strictly larger remainder to round up, which
  // turns the floor of >>> into round-half-away-from-zero.
  assign w_mask     = (ONE << in_right) - ONE;
  assign w_rem      = in_value & w_mask;
  assign w_thr      = (w_mask >> 1) + {{(WIDTH-1){1'b0}}, in_value[WIDTH-1]};
  assign w_quot     = in_value >>> in_right;
  assign w_round_up = w_rem > w_thr;
  assign w_result   = w_quot + $signed({{(WIDTH-1){1'b0}}, w_round_up});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_value <= w_result;
      out_tag   <= in_tag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/quant_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quant_pipe : 5-stage int32 -> OUT_WIDTH requantizer (bias, SRDHM, RDBP)|
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module quant_pipe
  import quant_pkg::*;
#(
  parameter int  CHANNELS  = 64,
  parameter int  ACC_WIDTH = 32,
  parameter int  OUT_WIDTH = 8,
  localparam int CH_W      = $clog2(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [2:0]                  cfg_sel,
  input  logic [CH_W-1:0]             cfg_chan,
  input  logic [ACC_WIDTH-1:0]        cfg_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [ACC_WIDTH-1:0] in_acc,
  input  logic [CH_W-1:0]             in_chan,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]             out_chan,
  output logic                        busy
);

  localparam int PROD_W = 2 * ACC_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACT_MAX_RST =
    ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] ACT_MIN_RST = ~ACT_MAX_RST;

  logic signed [ACC_WIDTH-1:0] bias_tab  [CHANNELS];
  logic signed [ACC_WIDTH-1:0] mult_tab  [CHANNELS];
  logic signed [ACC_WIDTH-1:0] shift_tab [CHANNELS];
  logic signed [ACC_WIDTH-1:0] act_min, act_max, out_offset;

  logic en;

  // Stage registers
  logic                        s1_valid;
  logic signed [ACC_WIDTH-1:0] s1_a, s1_mult;
  logic [4:0]                  s1_right;
  logic [CH_W-1:0]             s1_chan;

  logic                        s2_valid;
  logic signed [PROD_W-1:0]    s2_prod;
  logic                        s2_ovf;
  logic [4:0]                  s2_right;
  logic [CH_W-1:0]             s2_chan;

  logic                        s3_valid;
  stage_t                      s3_q;
  logic [4:0]                  s3_right;

  logic                        s4_valid;
  logic signed [ACC_WIDTH-1:0] s4_value;
  logic [STAGE_CH_W-1:0]       s4_tag;

  // Combinational stage logic
  logic signed [ACC_WIDTH-1:0] w_bias, w_shift, w_shc, w_x, w_a;
  logic [4:0]                  w_left, w_right;
  logic signed [PROD_W-1:0]    w_prod, w_sum, w_adj;
  logic signed [ACC_WIDTH-1:0] w_h, w_s4_in;
  stage_t                      w_s3_d;
  logic signed [ACC_WIDTH:0]   w_sum_ext;
  logic signed [ACC_WIDTH-1:0] w_y, w_clamped;
  logic                        unused_bits;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign busy     = s1_valid | s2_valid | s3_valid | s4_valid | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        bias_tab[i]  <= '0;
        mult_tab[i]  <= '0;
        shift_tab[i] <= '0;
      end
      act_min    <= ACT_MIN_RST;
      act_max    <= ACT_MAX_RST;
      out_offset <= '0;
    end else if (cfg_we) begin
      case (cfg_sel)
        SEL_BIAS:       bias_tab[cfg_chan]  <= cfg_data;
        SEL_MULT:       mult_tab[cfg_chan]  <= cfg_data;
        SEL_SHIFT:      shift_tab[cfg_chan] <= cfg_data;
        SEL_ACT_MIN:    act_min             <= cfg_data;
        SEL_ACT_MAX:    act_max             <= cfg_data;
        SEL_OUT_OFFSET: out_offset          <= cfg_data;
        default: ;
      endcase
    end
  end

  // S1: bias add and left shift
  assign w_bias  = bias_tab[in_chan];
  assign w_shift = shift_tab[in_chan];
  assign w_x     = in_acc + w_bias;
  assign w_a     = w_x << w_left;

  always_comb begin
    w_shc = w_shift;
    if (w_shift < SHIFT_MIN) w_shc = SHIFT_MIN;
    else if (w_shift > SHIFT_MAX) w_shc = SHIFT_MAX;
    w_left  = (w_shc > 0) ? 5'(w_shc)  : 5'd0;
    w_right = (w_shc < 0) ? 5'(-w_shc) : 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_mult  <= '0;
      s1_right <= '0;
      s1_chan  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_a     <= w_a;
      s1_mult  <= mult_tab[in_chan];
      s1_right <= w_right;
      s1_chan  <= in_chan;
    end
  end

  // S2: full-width product; INT_MIN*INT_MIN is the only SRDHM overflow
  assign w_prod = PROD_W'(s1_a) * PROD_W'(s1_mult);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_ovf   <= 1'b0;
      s2_right <= '0;
      s2_chan  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_prod  <= w_prod;
      s2_ovf   <= (s1_a == INT32_MIN) && (s1_mult == INT32_MIN);
      s2_right <= s1_right;
      s2_chan  <= s1_chan;
    end
  end

  // S3: nudge, then divide by 2^31 truncating toward zero
  assign w_sum = s2_prod + (s2_prod[PROD_W-1] ? SRDHM_NUDGE_NEG : SRDHM_NUDGE_POS);
  assign w_adj = w_sum + (w_sum[PROD_W-1] ? SRDHM_TRUNC_ADJ : 64'sd0);
  assign w_h   = w_adj[PROD_W-2:ACC_WIDTH-1];

  assign w_s3_d.value = w_h;
  assign w_s3_d.chan  = STAGE_CH_W'(s2_chan);
  assign w_s3_d.ovf   = s2_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_q     <= '0;
      s3_right <= '0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_q     <= w_s3_d;
      s3_right <= s2_right;
    end
  end

  // S4: overflow saturation, then rounding divide by power of two
  assign w_s4_in = s3_q.ovf ? INT32_MAX : s3_q.value;

  rdbp_stage #(
    .WIDTH   (ACC_WIDTH),
    .SHIFT_W (5),
    .TAG_W   (STAGE_CH_W)
  ) u_rdbp (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (s3_valid),
    .in_value  (w_s4_in),
    .in_right  (s3_right),
    .in_tag    (s3_q.chan),
    .out_valid (s4_valid),
    .out_value (s4_value),
    .out_tag   (s4_tag)
  );

  // S5: saturating offset add and activation clamp
  assign w_sum_ext = {s4_value[ACC_WIDTH-1], s4_value} + {out_offset[ACC_WIDTH-1], out_offset};

  always_comb begin
    if (w_sum_ext[ACC_WIDTH] != w_sum_ext[ACC_WIDTH-1])
      w_y = w_sum_ext[ACC_WIDTH] ? INT32_MIN : INT32_MAX;
    else
      w_y = w_sum_ext[ACC_WIDTH-1:0];
    if (w_y < act_min)      w_clamped = act_min;
    else if (w_y > act_max) w_clamped = act_max;
    else                    w_clamped = w_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (en) begin
      out_valid <= s4_valid;
      out_data  <= w_clamped[OUT_WIDTH-1:0];
      out_chan  <= s4_tag[CH_W-1:0];
    end
  end

  assign unused_bits = ^{s4_tag, w_clamped, w_adj[PROD_W-1], w_adj[ACC_WIDTH-2:0]};

endmodule
`default_nettype wire
